// File: rtl/stream_pool2x2.sv
// 2x2 stride-2 pooling over a raster pixel stream (average or max).
// Each pooled result is registered on the edge that accepts the odd-row/odd-column
// pixel closing its window. A pending result that downstream has not taken
// stalls the input.
module stream_pool2x2 #(
   parameter int DATA_W    = 32,
   parameter int WIDTH_IN  = 8,
   parameter int HEIGHT_IN = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int CW  = $clog2(WIDTH_IN);
   localparam int RW  = $clog2(HEIGHT_IN);
   localparam int HW  = WIDTH_IN / 2;
   localparam int LBW = (HW > 1) ? $clog2(HW) : 1;
   localparam int LBD = 1 << LBW;

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              mode_q;
   logic [DATA_W-1:0] hold;
   logic [DATA_W:0]   linebuf [LBD];

   logic              accept;
   logic              col_last;
   logic              row_last;
   logic              col_odd;
   logic              row_odd;
   logic [LBW-1:0]    lb_idx;
   logic [DATA_W:0]   lb_rd;
   logic [DATA_W-1:0] lb_max;
   logic [DATA_W:0]   sum2;
   logic [DATA_W+1:0] sum4;
   logic [DATA_W-1:0] max2;
   logic [DATA_W-1:0] max4;
   logic [DATA_W:0]   lb_wr;
   logic [DATA_W-1:0] result;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign col_last = (col == CW'(WIDTH_IN - 1));
   assign row_last = (row == RW'(HEIGHT_IN - 1));
   assign col_odd  = col[0];
   assign row_odd  = row[0];
   assign lb_idx   = LBW'(col >> 1);
   assign lb_rd    = linebuf[lb_idx];
   assign lb_max   = lb_rd[DATA_W-1:0];

   // Pair and window combine. The average keeps the full four-pixel sum
   // (two extra bits) and divides once, so no precision is lost per pixel.
   always_comb begin
      sum2   = {1'b0, hold} + {1'b0, in_data};
      sum4   = {1'b0, lb_rd} + {2'b00, hold} + {2'b00, in_data};
      max2   = (in_data > hold) ? in_data : hold;
      max4   = (lb_max > max2) ? lb_max : max2;
      lb_wr  = mode_q ? {1'b0, max2} : sum2;
      result = mode_q ? max4 : sum4[DATA_W+1:2];
   end

   // Raster position, per-frame mode capture and the even-column hold register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col    <= '0;
         row    <= '0;
         mode_q <= 1'b0;
         hold   <= '0;
      end else if (accept) begin
         if (col == '0 && row == '0) mode_q <= mode;
         if (!col_odd) hold <= in_data;
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffer holds even-row pair results; every entry is rewritten in
   // each even row before the odd row reads it, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept && !row_odd && col_odd) linebuf[lb_idx] <= lb_wr;
   end

   // Output register: load on a window-closing pixel, otherwise clear on transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (accept && row_odd && col_odd) begin
         out_valid <= 1'b1;
         out_data  <= result;
         out_last  <= row_last && col_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_pool2x2.sv
// Bench for stream_pool2x2 (4x4 frames, 8-bit pixels). A frame array model
// computes each pooled value from the stored pixels of its 2x2 window.
module tb_stream_pool2x2;

   localparam int DW = 8;
   localparam int WI = 4;
   localparam int HI = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          mode = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;

   stream_pool2x2 #(.DATA_W(DW), .WIDTH_IN(WI), .HEIGHT_IN(HI)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int          mcol = 0;
   int          mrow = 0;
   logic        mmode = 1'b0;
   int          frm [HI][WI];
   logic [DW:0] exp_q [$];
   int          obs_q [$];
   bit          no_stall = 0;
   bit          rand_ready = 0;

   // Every transfer is checked against the model queue and logged.
   always @(negedge clk) begin
      #2;
      if (reset_n && out_valid && out_ready) begin
         logic [DW:0] e;
         tests++;
         assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL xfer_unexpected got data=%0d last=%b expected no output", out_data, out_last);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         tests++;
         assert ({out_last, out_data} === e) else begin
            fails++;
            $error("FAIL xfer got data=%0d last=%b expected data=%0d last=%b",
                   out_data, out_last, e[DW-1:0], e[DW]);
         end
         obs_q.push_back(int'(out_data));
      end
   end

   function automatic int pool_ref(input int r, input int c, input logic m);
      int p [4];
      int best;
      p[0] = frm[r-1][c-1]; p[1] = frm[r-1][c]; p[2] = frm[r][c-1]; p[3] = frm[r][c];
      if (!m) return (p[0] + p[1] + p[2] + p[3]) / 4;
      best = 0;
      for (int k = 0; k < 4; k++) if (p[k] > best) best = p[k];
      return best;
   endfunction

   task automatic send_pixel(input int d, input logic m);
      logic acc;
      logic rdy;
      int   tries;
      int   e;
      logic el;
      acc = 1'b0;
      rdy = 1'b0;
      tries = 0;
      while (!acc) begin
         @(negedge clk);
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         in_data  = DW'(d);
         mode     = m;
         #1;
         acc = in_ready;
         rdy = out_ready;
         if (no_stall) begin
            tests++;
            assert (in_ready === 1'b1) else begin
               fails++;
               $error("FAIL no_stall in_ready=%b expected 1", in_ready);
            end
         end
         @(posedge clk);
         if (!acc) begin
            tries++;
            if (tries > 100) begin
               tests++;
               fails++;
               $error("FAIL accept_timeout pixel=%0d not accepted expected acceptance", d);
               in_valid = 1'b0;
               return;
            end
         end
      end
      if (mcol == 0 && mrow == 0) mmode = m;
      frm[mrow][mcol] = d;
      #1;
      in_valid = 1'b0;
      if (mrow % 2 == 1 && mcol % 2 == 1) begin
         e  = pool_ref(mrow, mcol, mmode);
         el = (mrow == HI - 1) && (mcol == WI - 1);
         exp_q.push_back({el, DW'(e)});
         tests++;
         assert (out_valid === 1'b1 && out_data === DW'(e) && out_last === el) else begin
            fails++;
            $error("FAIL latency got v=%b data=%0d last=%b expected v=1 data=%0d last=%b",
                   out_valid, out_data, out_last, e, el);
         end
      end else if (rdy) begin
         tests++;
         assert (out_valid === 1'b0) else begin
            fails++;
            $error("FAIL spurious_out got out_valid=%b expected 0 at r=%0d c=%0d", out_valid, mrow, mcol);
         end
      end
      if (mcol == WI - 1) begin
         mcol = 0;
         mrow = (mrow == HI - 1) ? 0 : mrow + 1;
      end else begin
         mcol++;
      end
   endtask

   // kind 0: pixel value equals its raster index; kind 1: random pixels.
   // Mode m_a is driven before pixel index sw, m_b from there on.
   task automatic send_frame(input int kind, input logic m_a, input logic m_b, input int sw);
      for (int i = 0; i < WI * HI; i++)
         send_pixel((kind == 0) ? i : int'($urandom_range(0, 255)), (i < sw) ? m_a : m_b);
   endtask

   task automatic check_obs(input string tag, input int n, input int e [8]);
      bit ok;
      @(negedge clk);
      #3;
      ok = (obs_q.size() == n);
      for (int i = 0; i < n; i++) if (ok && obs_q[i] != e[i]) ok = 0;
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL %s got n=%0d first=%0d,%0d,%0d,%0d expected n=%0d first=%0d,%0d,%0d,%0d",
                tag, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1, (obs_q.size() > 1) ? obs_q[1] : -1,
                (obs_q.size() > 2) ? obs_q[2] : -1, (obs_q.size() > 3) ? obs_q[3] : -1,
                n, e[0], e[1], e[2], e[3]);
      end
      obs_q.delete();
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      #1;
      tests++;
      assert (out_valid === 1'b0 && out_last === 1'b0 && out_data === '0) else begin
         fails++;
         $error("FAIL reset got v=%b last=%b data=%0d expected 0 0 0", out_valid, out_last, out_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      tests++;
      assert (in_ready === 1'b1) else begin
         fails++;
         $error("FAIL reset_ready got in_ready=%b expected 1", in_ready);
      end

      // Ramp frame averaged then max, back-to-back with no input stall
      no_stall = 1;
      send_frame(0, 1'b0, 1'b0, 0);
      send_frame(0, 1'b1, 1'b1, 0);
      no_stall = 0;
      check_obs("ramp_avg_max", 8, '{2, 4, 10, 12, 5, 7, 13, 15});

      // Near-full-scale window: sum must not overflow or round per pixel
      begin
         int tbl [16] = '{255, 255, 0, 0, 255, 254, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
         for (int i = 0; i < 16; i++) send_pixel(tbl[i], 1'b0);
      end
      check_obs("avg_fullscale", 4, '{254, 0, 0, 0, 0, 0, 0, 0});

      // Downstream stall for five cycles with a result pending
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_pixel(i, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(6);
      for (int k = 0; k < 5; k++) begin
         #1;
         tests++;
         assert (in_ready === 1'b0 && out_valid === 1'b1 && out_data === DW'(2)) else begin
            fails++;
            $error("FAIL stall_hold got rdy=%b v=%b data=%0d expected rdy=0 v=1 data=2",
                   in_ready, out_valid, out_data);
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 6; i < 16; i++) send_pixel(i, 1'b0);
      no_stall = 1;
      send_frame(0, 1'b0, 1'b0, 0);
      no_stall = 0;
      check_obs("stall_then_stream", 8, '{2, 4, 10, 12, 2, 4, 10, 12});

      // Mode flips mid-frame: that frame stays averaged, the next is max
      send_frame(0, 1'b0, 1'b1, 6);
      send_frame(0, 1'b1, 1'b1, 0);
      check_obs("mode_latch", 8, '{2, 4, 10, 12, 5, 7, 13, 15});

      // Reset mid-frame while a result is pending
      for (int i = 0; i < 7; i++) send_pixel(i, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      send_pixel(7, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      tests++;
      assert (out_valid === 1'b0 && out_last === 1'b0) else begin
         fails++;
         $error("FAIL reset_mid got v=%b last=%b expected 0 0", out_valid, out_last);
      end
      exp_q.delete();
      obs_q.delete();
      mcol = 0;
      mrow = 0;
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      send_frame(0, 1'b0, 1'b0, 0);
      check_obs("after_reset", 4, '{2, 4, 10, 12, 0, 0, 0, 0});

      // Random frames and modes with random downstream backpressure
      rand_ready = 1;
      for (int f = 0; f < 6; f++) begin
         logic m;
         m = 1'($urandom_range(0, 1));
         send_frame(1, m, m, 0);
      end
      rand_ready = 0;
      @(negedge clk);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL random_drain got %0d results outstanding expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
